// File: rtl/address_router_pkg.sv
// Shared definitions for the address router: FSM states, bus-error causes and
// the default memory map (SDRAM at 0, hwregs at 0xE000_0000, imem at 0xFFFF_0000).
package address_router_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_ERR  = 2'd2
  } state_e;

  typedef enum logic [1:0] {
    CAUSE_NONE     = 2'd0,
    CAUSE_UNMAPPED = 2'd1,
    CAUSE_TIMEOUT  = 2'd2
  } err_cause_e;

  localparam int DEF_NUM_TARGETS = 3;
  localparam logic [32*DEF_NUM_TARGETS-1:0] DEF_BASES =
    {32'hFFFF0000, 32'hE0000000, 32'h00000000};
  localparam logic [32*DEF_NUM_TARGETS-1:0] DEF_MASKS =
    {32'hFFFF0000, 32'hFFFF0000, 32'hFC000000};
  localparam int DEF_TIMEOUT = 255;

  function automatic int idx_width(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/address_router_if.sv
// CPU-side and target-side signals of the address router, with a debug view of the FSM state.
interface address_router_if #(
  parameter int NUM_TARGETS = 3
);
  import address_router_pkg::*;

  // Handshake: the CPU raises cpu_request with cpu_address and holds both until a
  // cycle where cpu_ready=1; that cycle is the transfer. The response is a single
  // cpu_ack pulse, cpu_error and cpu_rdata are meaningful only while cpu_ack=1.
  // tgt_request is a one-cycle strobe; the target answers with a one-cycle tgt_ack.
  logic                     cpu_request;
  logic [31:0]              cpu_address;
  logic                     cpu_ready;
  logic                     cpu_ack;
  logic [31:0]              cpu_rdata;
  logic                     cpu_error;
  logic [31:0]              err_address;
  logic [1:0]               err_cause;
  logic [NUM_TARGETS-1:0]   tgt_request;
  logic [NUM_TARGETS-1:0]   tgt_ack;
  logic [32*NUM_TARGETS-1:0] tgt_rdata;
  state_e                   dbg_state;

  modport slave (
    input  cpu_request, cpu_address, tgt_ack, tgt_rdata,
    output cpu_ready, cpu_ack, cpu_rdata, cpu_error, err_address, err_cause,
           tgt_request, dbg_state
  );

  modport master (
    output cpu_request, cpu_address, tgt_ack, tgt_rdata,
    input  cpu_ready, cpu_ack, cpu_rdata, cpu_error, err_address, err_cause,
           tgt_request, dbg_state
  );

endinterface

// File: rtl/address_router_region_match.sv
// Combinational base/mask decode over all regions; the lowest matching index wins.
module address_router_region_match
  import address_router_pkg::*;
#(
  parameter int                N     = DEF_NUM_TARGETS,
  parameter logic [32*N-1:0]   BASES = DEF_BASES,
  parameter logic [32*N-1:0]   MASKS = DEF_MASKS,
  parameter int                IW    = idx_width(N)
) (
  input  logic [31:0]   addr_i,
  output logic          hit_o,
  output logic [IW-1:0] idx_o
);

  // Scanning from the top down lets lower regions overwrite higher ones on overlap.
  always_comb begin
    hit_o = 1'b0;
    idx_o = '0;
    for (int i = N - 1; i >= 0; i--) begin
      if ((addr_i & MASKS[32*i +: 32]) == BASES[32*i +: 32]) begin
        hit_o = 1'b1;
        idx_o = IW'(i);
      end
    end
  end

endmodule

// File: rtl/address_router.sv
// Routes CPU requests to memory-mapped targets, tracks the outstanding target,
// and returns either its data or a registered bus error with captured cause.
module address_router
  import address_router_pkg::*;
#(
  parameter int                          NUM_TARGETS = DEF_NUM_TARGETS,
  parameter logic [32*NUM_TARGETS-1:0]   BASES       = DEF_BASES,
  parameter logic [32*NUM_TARGETS-1:0]   MASKS       = DEF_MASKS,
  parameter int                          TIMEOUT     = DEF_TIMEOUT
) (
  input  logic              clock,
  input  logic              reset,
  address_router_if.slave   bus
);

  localparam int IW = idx_width(NUM_TARGETS);
  localparam int TW = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;

  state_e                 state_q, state_d;
  logic [IW-1:0]          idx_q, idx_d;
  logic [31:0]            addr_q, addr_d;
  logic [TW-1:0]          timer_q, timer_d;
  logic                   ack_q, ack_d;
  logic                   error_q, error_d;
  logic [31:0]            rdata_q, rdata_d;
  logic [31:0]            err_addr_q, err_addr_d;
  err_cause_e             err_cause_q, err_cause_d;
  logic [NUM_TARGETS-1:0] tgt_req;
  logic                   hit;
  logic [IW-1:0]          hit_idx;

  address_router_region_match #(
    .N     (NUM_TARGETS),
    .BASES (BASES),
    .MASKS (MASKS),
    .IW    (IW)
  ) u_match (
    .addr_i (bus.cpu_address),
    .hit_o  (hit),
    .idx_o  (hit_idx)
  );

  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    addr_d      = addr_q;
    timer_d     = timer_q;
    ack_d       = 1'b0;
    error_d     = 1'b0;
    rdata_d     = '0;
    err_addr_d  = err_addr_q;
    err_cause_d = err_cause_q;
    tgt_req     = '0;
    case (state_q)
      ST_IDLE: begin
        if (bus.cpu_request) begin
          addr_d = bus.cpu_address;
          if (hit) begin
            tgt_req[hit_idx] = 1'b1;
            idx_d            = hit_idx;
            timer_d          = '0;
            // A target may answer in the very cycle it is strobed.
            if (bus.tgt_ack[hit_idx]) begin
              ack_d   = 1'b1;
              rdata_d = bus.tgt_rdata[32*hit_idx +: 32];
            end else begin
              state_d = ST_WAIT;
            end
          end else begin
            state_d     = ST_ERR;
            ack_d       = 1'b1;
            error_d     = 1'b1;
            err_addr_d  = bus.cpu_address;
            err_cause_d = CAUSE_UNMAPPED;
          end
        end
      end
      ST_WAIT: begin
        // The ack is checked before the timeout so a last-cycle ack still succeeds.
        if (bus.tgt_ack[idx_q]) begin
          state_d = ST_IDLE;
          ack_d   = 1'b1;
          rdata_d = bus.tgt_rdata[32*idx_q +: 32];
        end else if (timer_q == TW'(TIMEOUT)) begin
          state_d     = ST_ERR;
          ack_d       = 1'b1;
          error_d     = 1'b1;
          err_addr_d  = addr_q;
          err_cause_d = CAUSE_TIMEOUT;
        end else begin
          timer_d = timer_q + TW'(1);
        end
      end
      ST_ERR:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      idx_q       <= '0;
      addr_q      <= '0;
      timer_q     <= '0;
      ack_q       <= 1'b0;
      error_q     <= 1'b0;
      rdata_q     <= '0;
      err_addr_q  <= '0;
      err_cause_q <= CAUSE_NONE;
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      addr_q      <= addr_d;
      timer_q     <= timer_d;
      ack_q       <= ack_d;
      error_q     <= error_d;
      rdata_q     <= rdata_d;
      err_addr_q  <= err_addr_d;
      err_cause_q <= err_cause_d;
    end
  end

  assign bus.cpu_ready   = (state_q == ST_IDLE);
  assign bus.cpu_ack     = ack_q;
  assign bus.cpu_error   = error_q;
  assign bus.cpu_rdata   = rdata_q;
  assign bus.err_address = err_addr_q;
  assign bus.err_cause   = err_cause_q;
  assign bus.tgt_request = tgt_req;
  assign bus.dbg_state   = state_q;

endmodule

// File: tb/tb_address_router.sv
// Directed bench for address_router: stimulus pushes expected responses,
// a negedge monitor pops and compares them whenever cpu_ack is seen.
module tb_address_router;
  import address_router_pkg::*;

  localparam int NT = 3;

  logic clock;
  logic reset;

  address_router_if #(.NUM_TARGETS(NT)) bus ();

  address_router #(
    .NUM_TARGETS (NT),
    .BASES       (DEF_BASES),
    .MASKS       (DEF_MASKS),
    .TIMEOUT     (8)
  ) dut (
    .clock (clock),
    .reset (reset),
    .bus   (bus)
  );

  // clock / reset
  initial clock = 1'b0;
  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // {error, rdata} per expected ack; {cause, address} per expected error ack
  logic [32:0] exp_q[$];
  logic [33:0] err_q[$];
  logic [32:0] e_ack;
  logic [33:0] e_err;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // scoreboard monitor
  always @(negedge clock) begin
    if (!reset && bus.cpu_ack === 1'b1) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_ack: got ack rdata=%0h error=%0b, required no ack",
                 bus.cpu_rdata, bus.cpu_error);
      end else begin
        e_ack = exp_q.pop_front();
        check("ack_error", 64'(bus.cpu_error), 64'(e_ack[32]));
        check("ack_rdata", 64'(bus.cpu_rdata), 64'(e_ack[31:0]));
        if (e_ack[32] && err_q.size() > 0) begin
          e_err = err_q.pop_front();
          check("err_cause", 64'(bus.err_cause), 64'(e_err[33:32]));
          check("err_address", 64'(bus.err_address), 64'(e_err[31:0]));
        end
      end
    end
  end

  // driver tasks
  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic push_ok(input logic [31:0] data);
    exp_q.push_back({1'b0, data});
  endtask

  task automatic push_err(input logic [1:0] cause, input logic [31:0] addr);
    exp_q.push_back({1'b1, 32'h0});
    err_q.push_back({cause, addr});
  endtask

  task automatic send_req(input logic [31:0] addr, input logic [NT-1:0] exp_req);
    bus.cpu_request = 1'b1;
    bus.cpu_address = addr;
    #1;
    check("req_ready", 64'(bus.cpu_ready), 64'(1));
    check("tgt_request", 64'(bus.tgt_request), 64'(exp_req));
    tick();
    bus.cpu_request = 1'b0;
    #1;
    check("tgt_request_one_cycle", 64'(bus.tgt_request), 64'(0));
  endtask

  task automatic pulse_ack(input int t, input logic [31:0] data);
    bus.tgt_ack[t] = 1'b1;
    bus.tgt_rdata[32*t +: 32] = data;
    tick();
    bus.tgt_ack = '0;
    check("ack_latency", 64'(bus.cpu_ack), 64'(1));
    check("ack_ok_error", 64'(bus.cpu_error), 64'(0));
    check("ready_after_ack", 64'(bus.cpu_ready), 64'(1));
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_ready"}, 64'(bus.cpu_ready), 64'(1));
    check({tag, "_ack"}, 64'(bus.cpu_ack), 64'(0));
    check({tag, "_error"}, 64'(bus.cpu_error), 64'(0));
    check({tag, "_rdata"}, 64'(bus.cpu_rdata), 64'(0));
    check({tag, "_tgt_request"}, 64'(bus.tgt_request), 64'(0));
    check({tag, "_err_address"}, 64'(bus.err_address), 64'(0));
    check({tag, "_err_cause"}, 64'(bus.err_cause), 64'(0));
    check({tag, "_state"}, 64'(bus.dbg_state), 64'(ST_IDLE));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int cnt;
    reset           = 1'b1;
    bus.cpu_request = 1'b0;
    bus.cpu_address = '0;
    bus.tgt_ack     = '0;
    bus.tgt_rdata   = '0;
    repeat (2) @(posedge clock);
    #1;
    check_reset_values("reset");
    reset = 1'b0;
    tick();

    // SDRAM read, ack three cycles after the request
    push_ok(32'hDEADBEEF);
    send_req(32'h00001000, 3'b001);
    tick();
    tick();
    pulse_ack(0, 32'hDEADBEEF);

    // hwregs then imem
    push_ok(32'h12345678);
    send_req(32'hE0000010, 3'b010);
    pulse_ack(1, 32'h12345678);
    push_ok(32'h9ABCDEF0);
    send_req(32'hFFFF0004, 3'b100);
    pulse_ack(2, 32'h9ABCDEF0);

    // unmapped address
    push_err(CAUSE_UNMAPPED, 32'h80000000);
    send_req(32'h80000000, 3'b000);
    check("unmapped_ack", 64'(bus.cpu_ack), 64'(1));
    check("unmapped_error", 64'(bus.cpu_error), 64'(1));
    check("unmapped_ready", 64'(bus.cpu_ready), 64'(0));
    tick();
    check("ready_after_err", 64'(bus.cpu_ready), 64'(1));
    check("ack_after_err", 64'(bus.cpu_ack), 64'(0));

    // success leaves the captured error untouched
    push_ok(32'h0BADF00D);
    send_req(32'h00000004, 3'b001);
    pulse_ack(0, 32'h0BADF00D);
    check("err_hold_address", 64'(bus.err_address), 64'h80000000);
    check("err_hold_cause", 64'(bus.err_cause), 64'(CAUSE_UNMAPPED));

    // ack in the same cycle as the request
    push_ok(32'hCAFEF00D);
    bus.tgt_ack[0] = 1'b1;
    bus.tgt_rdata[31:0] = 32'hCAFEF00D;
    send_req(32'h00002000, 3'b001);
    bus.tgt_ack = '0;
    check("same_cycle_ack", 64'(bus.cpu_ack), 64'(1));
    check("same_cycle_ready", 64'(bus.cpu_ready), 64'(1));

    // stray ack while idle
    tick();
    bus.tgt_ack[1] = 1'b1;
    tick();
    bus.tgt_ack = '0;
    check("idle_stray_ack", 64'(bus.cpu_ack), 64'(0));

    // timeout: nine waiting cycles, then the error ack
    push_err(CAUSE_TIMEOUT, 32'h00000040);
    send_req(32'h00000040, 3'b001);
    cnt = 0;
    for (int i = 0; i < 40 && bus.cpu_ack !== 1'b1; i++) begin
      if (bus.cpu_ready === 1'b0) cnt++;
      tick();
    end
    check("timeout_wait_cycles", 64'(cnt), 64'(9));
    check("timeout_ack", 64'(bus.cpu_ack), 64'(1));
    check("timeout_error", 64'(bus.cpu_error), 64'(1));
    tick();
    check("ready_after_timeout", 64'(bus.cpu_ready), 64'(1));

    // ack from a non-selected target is ignored
    push_ok(32'h22222222);
    send_req(32'h00000100, 3'b001);
    bus.tgt_ack[1] = 1'b1;
    bus.tgt_rdata[63:32] = 32'h11111111;
    tick();
    bus.tgt_ack = '0;
    check("wrong_target_ack", 64'(bus.cpu_ack), 64'(0));
    check("wrong_target_ready", 64'(bus.cpu_ready), 64'(0));
    pulse_ack(0, 32'h22222222);

    // ack on the exact timeout cycle wins
    push_ok(32'h33333333);
    send_req(32'h00000200, 3'b001);
    repeat (8) tick();
    pulse_ack(0, 32'h33333333);

    // reset in the middle of a wait, then a stray ack
    send_req(32'h00000300, 3'b001);
    tick();
    reset = 1'b1;
    #1;
    check_reset_values("midreset");
    tick();
    reset = 1'b0;
    bus.tgt_ack[0] = 1'b1;
    bus.tgt_rdata[31:0] = 32'h44444444;
    tick();
    bus.tgt_ack = '0;
    check("post_reset_stray_ack", 64'(bus.cpu_ack), 64'(0));
    check("post_reset_ready", 64'(bus.cpu_ready), 64'(1));
    tick();

    check("exp_queue_drained", 64'(exp_q.size()), 64'(0));
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
